// File: rtl/seg7_num_display.sv
// Multi-digit seven-segment driver: binary value -> decimal (double-dabble) or hex glyphs.
// Latency: WIDTH+1 cycles from load edge in decimal mode, 1 cycle in hex mode.
// Backpressure: load is accepted only while idle (busy=0); load while busy is ignored.
module seg7_num_display #(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WIDTH-1:0]      value,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    output logic [7*DIGITS-1:0]   hex,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    // BCD digits needed to hold any WIDTH-bit value, and hex nibbles covering WIDTH bits
    localparam int ACC  = (WIDTH + 4) / 3;
    localparam int HNIB = (WIDTH + 3) / 4;
    // Padded widths so every displayed digit has a source nibble (missing ones read as 0)
    localparam int NB   = (ACC  > DIGITS) ? ACC  : DIGITS;
    localparam int NV   = (HNIB > DIGITS) ? HNIB : DIGITS;
    localparam int CW   = $clog2(WIDTH + 1);

    localparam logic [6:0] GLYPH_DASH  = 7'b1111110;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [WIDTH-1:0]    cap_val;
    logic [WIDTH-1:0]    shreg;
    logic                cap_hex;
    logic                cap_blank;
    logic [4*ACC-1:0]    bcd;
    logic [4*ACC-1:0]    bcd_adj;
    logic [CW-1:0]       cnt;
    logic [4*NB-1:0]     bcd_pad;
    logic [4*NV-1:0]     val_pad;
    logic [7*DIGITS-1:0] hex_nxt;
    logic                ovf_nxt;
    logic                lead;
    logic [3:0]          nib;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0:    glyph = 7'b0000001;
            4'h1:    glyph = 7'b1001111;
            4'h2:    glyph = 7'b0010010;
            4'h3:    glyph = 7'b0000110;
            4'h4:    glyph = 7'b1001100;
            4'h5:    glyph = 7'b0100100;
            4'h6:    glyph = 7'b0100000;
            4'h7:    glyph = 7'b0001111;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0001100;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b1100000;
            4'hC:    glyph = 7'b0110001;
            4'hD:    glyph = 7'b1000010;
            4'hE:    glyph = 7'b0110000;
            default: glyph = 7'b0111000;
        endcase
    endfunction

    assign busy = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: decimal goes through WIDTH shift cycles, hex goes straight to update
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = hex_mode ? UPDATE : CONV;
            CONV:    if (cnt == CW'(WIDTH - 1)) state_nxt = UPDATE;
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction applied to every BCD nibble before the shift
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < ACC; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
    end

    // Zero-extend sources so digit indexing never runs off the end
    always_comb begin
        bcd_pad                = '0;
        bcd_pad[4*ACC-1:0]     = bcd;
        val_pad                = '0;
        val_pad[WIDTH-1:0]     = cap_val;
    end

    // Final glyphs and overflow, computed from the captured value / finished BCD
    always_comb begin
        ovf_nxt = 1'b0;
        if (cap_hex) begin
            for (int k = DIGITS; k < NV; k++) begin
                if (val_pad[4*k +: 4] != 4'd0) ovf_nxt = 1'b1;
            end
        end else begin
            for (int k = DIGITS; k < NB; k++) begin
                if (bcd_pad[4*k +: 4] != 4'd0) ovf_nxt = 1'b1;
            end
        end
        hex_nxt = '1;
        lead    = 1'b1;
        nib     = 4'd0;
        // Walk from the most significant digit; lead stays set while all digits so far are 0
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib  = cap_hex ? val_pad[4*i +: 4] : bcd_pad[4*i +: 4];
            lead = lead & (nib == 4'd0);
            if (ovf_nxt)
                hex_nxt[7*i +: 7] = GLYPH_DASH;
            else if (cap_blank && lead && (i != 0))
                hex_nxt[7*i +: 7] = GLYPH_BLANK;
            else
                hex_nxt[7*i +: 7] = glyph(nib);
        end
    end

    // Capture, shift-add-3 engine and single-edge display update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hex       <= '1;
            done      <= 1'b0;
            overflow  <= 1'b0;
            cap_val   <= '0;
            cap_hex   <= 1'b0;
            cap_blank <= 1'b0;
            shreg     <= '0;
            bcd       <= '0;
            cnt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        cap_val   <= value;
                        cap_hex   <= hex_mode;
                        cap_blank <= blank_lz;
                        shreg     <= value;
                        bcd       <= '0;
                        cnt       <= '0;
                    end
                end
                CONV: begin
                    bcd   <= {bcd_adj[4*ACC-2:0], shreg[WIDTH-1]};
                    shreg <= shreg << 1;
                    cnt   <= cnt + CW'(1);
                end
                UPDATE: begin
                    hex      <= hex_nxt;
                    overflow <= ovf_nxt;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_num_display.sv
// Bench for seg7_num_display: latency-level model plus directed literal checks.
// Model tracks only accepted loads and a countdown to the display update.
// Inputs driven 2 time units after the rising edge; outputs compared on the falling edge.
module tb_seg7_num_display;

    localparam int DIGITS = 4;
    localparam int WIDTH  = 14;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  load;
    logic [WIDTH-1:0]      value;
    logic                  hex_mode;
    logic                  blank_lz;
    logic [7*DIGITS-1:0]   hex;
    logic                  busy;
    logic                  done;
    logic                  overflow;

    int total = 0;
    int bad   = 0;
    int n_done = 0;

    seg7_num_display #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value    (value),
        .hex_mode (hex_mode),
        .blank_lz (blank_lz),
        .hex      (hex),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    logic [6:0] gly [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit                  live = 0;
    int                  m_cnt = 0;
    int                  m_v;
    bit                  m_hm, m_bl;
    logic [7*DIGITS-1:0] m_hex = '1;
    bit                  m_ovf = 0;
    bit                  m_done = 0;

    task automatic model_display();
        int  d [DIGITS];
        int  p10;
        int  lim;
        bit  ld;
        lim = 1;
        for (int i = 0; i < DIGITS; i++) lim = lim * 10;
        m_ovf = m_hm ? ((m_v >> (4*DIGITS)) != 0) : (m_v >= lim);
        p10 = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d[i] = m_hm ? ((m_v >> (4*i)) & 15) : ((m_v / p10) % 10);
            p10 = p10 * 10;
        end
        ld = 1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (d[i] != 0) ld = 0;
            if (m_ovf)                   m_hex[7*i +: 7] = 7'b1111110;
            else if (m_bl && ld && i > 0) m_hex[7*i +: 7] = 7'b1111111;
            else                          m_hex[7*i +: 7] = gly[d[i]];
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            live   = 1;
            m_cnt  = 0;
            m_hex  = '1;
            m_ovf  = 0;
            m_done = 0;
        end else begin
            m_done = 0;
            if (m_cnt == 0) begin
                if (load) begin
                    m_v   = int'(value);
                    m_hm  = hex_mode;
                    m_bl  = blank_lz;
                    m_cnt = hex_mode ? 1 : WIDTH + 1;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    model_display();
                    m_done = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (live) begin
            check("cyc_hex",  32'(hex),      32'(m_hex));
            check("cyc_ovf",  32'(overflow), 32'(m_ovf));
            check("cyc_busy", 32'(busy),     32'(m_cnt != 0));
            check("cyc_done", 32'(done),     32'(m_done));
            if (done) n_done++;
        end
    end

    // Load once, scramble inputs, then wait (bounded) for done and check latency
    task automatic run(input logic [WIDTH-1:0] v, input logic hm, input logic bl, input int exp_lat);
        int n;
        value    = v;
        hex_mode = hm;
        blank_lz = bl;
        load     = 1'b1;
        @(posedge clk); #2;
        load     = 1'b0;
        value    = WIDTH'($urandom);
        hex_mode = 1'($urandom);
        blank_lz = 1'($urandom);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #2;
            n++;
        end
        check("latency", 32'(n), 32'(exp_lat));
    endtask

    initial begin
        int nd;
        rst_n    = 1'b0;
        load     = 1'b1;
        value    = 14'd1234;
        hex_mode = 1'b0;
        blank_lz = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_hex",  32'(hex),      32'h0FFF_FFFF);
        check("rst_busy", 32'(busy),     32'd0);
        check("rst_done", 32'(done),     32'd0);
        check("rst_ovf",  32'(overflow), 32'd0);
        rst_n = 1'b1;
        load  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("idle_busy", 32'(busy), 32'd0);

        run(14'd1234, 1'b0, 1'b0, 15);
        check("dec1234", 32'(hex), 32'({7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}));
        check("dec1234_ovf", 32'(overflow), 32'd0);

        run(14'd7, 1'b0, 1'b1, 15);
        check("blank7", 32'(hex), 32'({7'b1111111, 7'b1111111, 7'b1111111, 7'b0001111}));

        run(14'd0, 1'b0, 1'b1, 15);
        check("blank0", 32'(hex), 32'({7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}));

        run(14'd305, 1'b0, 1'b1, 15);
        check("blank305", 32'(hex), 32'({7'b1111111, 7'b0000110, 7'b0000001, 7'b0100100}));

        run(14'd42, 1'b0, 1'b0, 15);
        check("noblank42", 32'(hex), 32'({7'b0000001, 7'b0000001, 7'b1001100, 7'b0010010}));

        run(14'd12000, 1'b0, 1'b0, 15);
        check("ovf12000", 32'(hex), 32'({4{7'b1111110}}));
        check("ovf12000_flag", 32'(overflow), 32'd1);

        run(14'd9999, 1'b0, 1'b0, 15);
        check("dec9999", 32'(hex), 32'({4{7'b0001100}}));
        check("dec9999_flag", 32'(overflow), 32'd0);

        run(14'h2BEF, 1'b1, 1'b0, 1);
        check("hex2BEF", 32'(hex), 32'({7'b0010010, 7'b1100000, 7'b0110000, 7'b0111000}));

        run(14'h000A, 1'b1, 1'b1, 1);
        check("hexA_blank", 32'(hex), 32'({7'b1111111, 7'b1111111, 7'b1111111, 7'b0001000}));

        run(14'd10000, 1'b0, 1'b1, 15);
        check("ovf_noblank", 32'(hex), 32'({4{7'b1111110}}));

        // load held through two conversions: accepted at edges 0 and 16 only
        @(posedge clk); #2;
        nd       = n_done;
        value    = 14'd1234;
        hex_mode = 1'b0;
        blank_lz = 1'b0;
        load     = 1'b1;
        repeat (32) begin
            @(posedge clk); #2;
        end
        load = 1'b0;
        repeat (20) begin
            @(posedge clk); #2;
        end
        check("held_dones", 32'(n_done - nd), 32'd2);
        check("held_idle",  32'(busy), 32'd0);

        // reset in the middle of a conversion
        value = 14'd5678;
        load  = 1'b1;
        @(posedge clk); #2;
        load  = 1'b0;
        repeat (4) begin
            @(posedge clk); #2;
        end
        check("mid_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        check("midrst_hex",  32'(hex),  32'h0FFF_FFFF);
        check("midrst_busy", 32'(busy), 32'd0);
        nd = n_done;
        repeat (20) begin
            @(posedge clk); #2;
        end
        check("midrst_nodone", 32'(n_done - nd), 32'd0);
        check("midrst_hold",   32'(hex), 32'h0FFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
